// File: rtl/svc_rv_pkg.sv
// svc_rv_pkg: shared types for the RISC-V BRAM SoC blocks.
package svc_rv_pkg;
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DBG
  } rd_owner_t;
endpackage

// File: rtl/svc_rv_dmem_arb_starve.sv
// svc_rv_dmem_arb_starve: counts consecutive denied debug cycles and flags when debug must win.
module svc_rv_dmem_arb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_valid,
  input  logic dbg_grant,
  output logic starve_hit
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;
  always_ff @(posedge clk) begin
    if (rst || !dbg_valid || dbg_grant) starve_cnt <= '0;
    else starve_cnt <= starve_cnt + 1'b1;
  end
  assign starve_hit = starve_cnt == CW'(STARVE_MAX);
endmodule

// File: rtl/svc_rv_dmem_arb.sv
// svc_rv_dmem_arb: shares the data BRAM between core and debug bridge; SVC_RV_DMEM_ARB_STARVE_EN adds the debug starvation guard.
module svc_rv_dmem_arb
  import svc_rv_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_ren,
  input  logic [AW-1:0]   cpu_raddr,
  output logic [DW-1:0]   cpu_rdata,
  input  logic            cpu_wen,
  input  logic [AW-1:0]   cpu_waddr,
  input  logic [DW-1:0]   cpu_wdata,
  input  logic [DW/8-1:0] cpu_wstrb,
  output logic            cpu_stall,
  input  logic            dbg_valid,
  input  logic            dbg_write,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [DW-1:0]   dbg_wdata,
  input  logic [DW/8-1:0] dbg_wstrb,
  output logic            dbg_ready,
  output logic            dbg_rvalid,
  output logic [DW-1:0]   dbg_rdata,
  input  logic            dbg_halt,
  output logic            mem_ren,
  output logic [AW-1:0]   mem_raddr,
  input  logic [DW-1:0]   mem_rdata,
  output logic            mem_wen,
  output logic [AW-1:0]   mem_waddr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb
);
  logic cpu_req, cpu_grant, dbg_grant, starve_hit;
  rd_owner_t owner;
  logic [DW-1:0] cpu_rdata_q;
  assign cpu_req = cpu_ren | cpu_wen;
  assign dbg_grant = dbg_valid & ~rst & (dbg_halt | ~cpu_req | starve_hit);
  assign cpu_grant = cpu_req & ~dbg_grant & ~rst;
`ifdef SVC_RV_DMEM_ARB_STARVE_EN
  svc_rv_dmem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk(clk),
    .rst(rst),
    .dbg_valid(dbg_valid),
    .dbg_grant(dbg_grant),
    .starve_hit(starve_hit)
  );
`else
  assign starve_hit = 1'b0 & (STARVE_MAX > 0);
`endif
  always_comb begin
    mem_ren   = dbg_grant ? ~dbg_write : cpu_grant & cpu_ren;
    mem_raddr = dbg_grant ? dbg_addr : cpu_raddr;
    mem_wen   = dbg_grant ? dbg_write : cpu_grant & cpu_wen;
    mem_waddr = dbg_grant ? dbg_addr : cpu_waddr;
    mem_wdata = dbg_grant ? dbg_wdata : cpu_wdata;
    mem_wstrb = dbg_grant ? dbg_wstrb : cpu_wstrb;
  end
  assign cpu_stall = cpu_req & dbg_grant;
  assign dbg_ready = dbg_grant;
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_NONE;
      cpu_rdata_q <= '0;
    end else begin
      owner <= !mem_ren ? OWN_NONE : dbg_grant ? OWN_DBG : OWN_CPU;
      if (owner == OWN_CPU) cpu_rdata_q <= mem_rdata;
    end
  end
  // Cycles whose read belonged to debug keep showing the core its last word.
  assign cpu_rdata  = owner == OWN_CPU ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata  = mem_rdata;
  assign dbg_rvalid = owner == OWN_DBG && !rst;
endmodule

// File: tb/tb_svc_rv_dmem_arb.sv
// tb_svc_rv_dmem_arb: directed scoreboard bench for svc_rv_dmem_arb.
module tb_svc_rv_dmem_arb;
  localparam int AW = 32, DW = 32, SM = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_ren, cpu_wen, cpu_stall, dbg_valid, dbg_write, dbg_ready, dbg_rvalid, dbg_halt;
  logic mem_ren, mem_wen;
  logic [AW-1:0] cpu_raddr, cpu_waddr, dbg_addr, mem_raddr, mem_waddr;
  logic [DW-1:0] cpu_rdata, cpu_wdata, dbg_wdata, dbg_rdata, mem_rdata, mem_wdata;
  logic [DW/8-1:0] cpu_wstrb, dbg_wstrb, mem_wstrb;
  always #5 clk = ~clk;
  svc_rv_dmem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr), .cpu_rdata(cpu_rdata),
    .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_write(dbg_write), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_wstrb(dbg_wstrb), .dbg_ready(dbg_ready),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_halt(dbg_halt),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[4]  <= 32'hDEADBEEF;
      mem[12] <= 32'h00005555;
    end else if (mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_waddr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_ren) mem_rdata <= mem[mem_raddr[7:2]];
  end
  typedef enum {S_STALL, S_READY, S_RVALID, S_RDATA, S_CPU_RDATA, S_MREN, S_MWEN, S_MEM40} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] sample(sig_e s);
    case (s)
      S_STALL:     return {31'b0, cpu_stall};
      S_READY:     return {31'b0, dbg_ready};
      S_RVALID:    return {31'b0, dbg_rvalid};
      S_RDATA:     return dbg_rdata;
      S_CPU_RDATA: return cpu_rdata;
      S_MREN:      return {31'b0, mem_ren};
      S_MWEN:      return {31'b0, mem_wen};
      default:     return mem[16];
    endcase
  endfunction
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_chk++;
        if (sb[i].cyc < cyc) begin
          n_fail++;
          $display("FAIL %s cyc=%0d expired unchecked", sb[i].sig.name(), sb[i].cyc);
        end else if (sample(sb[i].sig) !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", sb[i].sig.name(), cyc, sample(sb[i].sig), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end
  task automatic exp(input sig_e s, input logic [31:0] v);
    sb.push_back('{cyc, s, v});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    cpu_ren = 0; cpu_raddr = '0; cpu_wen = 0; cpu_waddr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    dbg_valid = 0; dbg_write = 0; dbg_addr = '0; dbg_wdata = '0; dbg_wstrb = '0; dbg_halt = 0;
  endtask
  task automatic dbg_req(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    dbg_valid = 1; dbg_write = wr; dbg_addr = a; dbg_wdata = d; dbg_wstrb = s;
  endtask
  task automatic starve_seq();
    for (int i = 1; i <= 11; i++) begin
      step(); idle();
      cpu_ren = 1; cpu_raddr = 32'h10;
      if (i != 11) dbg_req(0, 32'h30, '0, '0);
`ifdef SVC_RV_DMEM_ARB_STARVE_EN
      exp(S_READY, 32'(i == 5 || i == 10));
      exp(S_STALL, 32'(i == 5 || i == 10));
      exp(S_RVALID, 32'(i == 6 || i == 11));
      if (i == 6 || i == 11) exp(S_RDATA, 32'h5555);
`else
      exp(S_READY, 0);
      exp(S_STALL, 0);
      exp(S_RVALID, 0);
`endif
      if (i == 6) exp(S_CPU_RDATA, 32'hDEADBEEF);
    end
    step(); idle();
  endtask
  initial begin
    idle(); rst = 1;
    step(); cpu_ren = 1; cpu_wen = 1; dbg_req(0, 32'h30, '0, '0);
    exp(S_MREN, 0); exp(S_MWEN, 0); exp(S_READY, 0); exp(S_STALL, 0);
    step(); rst = 0; idle();
    exp(S_RVALID, 0); exp(S_CPU_RDATA, 0);
    step(); cpu_ren = 1; cpu_raddr = 32'h10;
    exp(S_STALL, 0); exp(S_MREN, 1);
    step(); idle(); exp(S_CPU_RDATA, 32'hDEADBEEF); exp(S_STALL, 0);
    step(); exp(S_CPU_RDATA, 32'hDEADBEEF);
    step(); dbg_req(1, 32'h20, 32'h1234, 4'hF);
    exp(S_READY, 1); exp(S_MWEN, 1); exp(S_MREN, 0);
    step(); dbg_req(0, 32'h20, '0, '0);
    exp(S_READY, 1); exp(S_MREN, 1); exp(S_RVALID, 0);
    step(); idle(); exp(S_RVALID, 1); exp(S_RDATA, 32'h1234);
    step(); dbg_req(1, 32'h20, 32'hFFFFFFFF, 4'h2); exp(S_READY, 1); exp(S_RVALID, 0);
    step(); dbg_req(0, 32'h20, '0, '0); exp(S_RVALID, 0);
    step(); idle(); exp(S_RVALID, 1); exp(S_RDATA, 32'h0000FF34);
    step(); exp(S_RVALID, 0);
    starve_seq();
    step(); cpu_wen = 1; cpu_waddr = 32'h10; cpu_wdata = 32'hAAAA0000; cpu_wstrb = 4'hF;
    exp(S_MWEN, 1); exp(S_STALL, 0);
    step(); idle(); cpu_ren = 1; cpu_raddr = 32'h10; exp(S_MREN, 1);
    step(); dbg_req(0, 32'h30, '0, '0); dbg_halt = 1;
    exp(S_STALL, 1); exp(S_READY, 1); exp(S_CPU_RDATA, 32'hAAAA0000);
    step(); dbg_valid = 0; dbg_halt = 0;
    exp(S_STALL, 0); exp(S_CPU_RDATA, 32'hAAAA0000); exp(S_RVALID, 1); exp(S_RDATA, 32'h5555);
    step(); idle(); exp(S_CPU_RDATA, 32'hAAAA0000);
    for (int i = 0; i < 5; i++) begin
      step(); idle();
      cpu_ren = 1; cpu_raddr = 32'h10;
      cpu_wen = 1; cpu_waddr = 32'h40; cpu_wdata = 32'h0BAD; cpu_wstrb = 4'hF;
      dbg_req(0, 32'h30, '0, '0); dbg_halt = i < 4;
      exp(S_STALL, 32'(i < 4)); exp(S_READY, 32'(i < 4)); exp(S_MWEN, 32'(i == 4)); exp(S_MREN, 1);
      if (i > 0) begin exp(S_RVALID, 1); exp(S_RDATA, 32'h5555); end
      if (i == 4) exp(S_MEM40, 0);
    end
    step(); idle(); dbg_req(0, 32'h30, '0, '0); exp(S_READY, 1);
    step(); idle(); rst = 1; cpu_ren = 1; cpu_wen = 1; dbg_valid = 1;
    exp(S_RVALID, 0); exp(S_MREN, 0); exp(S_MWEN, 0); exp(S_STALL, 0); exp(S_READY, 0);
    step(); exp(S_RVALID, 0);
    step(); rst = 0; idle(); exp(S_RVALID, 0); exp(S_CPU_RDATA, 0);
    starve_seq();
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/svc_rv_dmem_arb.md
# svc_rv_dmem_arb

Arbiter that shares the SoC data-memory BRAM (one read port with 1-cycle latency, one byte-strobed write port) between the RISC-V core's data port and the debug bridge, which loads programs and peeks/pokes memory. It sits between the core/debug logic and the data memory inside the BRAM SoC. CPU has priority, with a bounded starvation guard for debug. Read data returned to the core stays stable across cycles stolen by debug.

## Interface
- `AW`, 32, address width (byte address, passed through untranslated)
- `DW`, 32, data width; strobe width is DW/8
- `STARVE_MAX`, 4, consecutive denied debug cycles before debug wins one cycle (≥1)

- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `cpu_ren`/`cpu_raddr` in 1/AW: core read request/address
- `cpu_rdata` out DW: core read data
- `cpu_wen`/`cpu_waddr`/`cpu_wdata`/`cpu_wstrb` in 1/AW/DW/DW/8: core write
- `cpu_stall` out 1: core request not serviced this cycle; core holds the request
- `dbg_valid`/`dbg_write` in 1/1: debug request valid; 1 = write, 0 = read
- `dbg_addr`/`dbg_wdata`/`dbg_wstrb` in AW/DW/DW/8: debug request payload
- `dbg_ready` out 1: debug request accepted this cycle
- `dbg_rvalid`/`dbg_rdata` out 1/DW: debug read response
- `dbg_halt` in 1: debug owns memory unconditionally
- `mem_ren`/`mem_raddr`/`mem_rdata` out/out/in 1/AW/DW: BRAM read port
- `mem_wen`/`mem_waddr`/`mem_wdata`/`mem_wstrb` out 1/AW/DW/DW/8: BRAM write port

## Operation
- `cpu_req = cpu_ren | cpu_wen`. A grant covers both BRAM ports for one cycle.
- `dbg_grant = dbg_valid & !rst & (dbg_halt | !cpu_req | starve_hit)`. Otherwise the CPU owns the ports.
- On a CPU grant, read and write pass through together. Simultaneous CPU read and write is legal.
- On a debug grant, exactly one port is driven (selected by `dbg_write`). `mem_wstrb = dbg_wstrb`.
- `cpu_stall = cpu_req & dbg_grant`. `dbg_ready = dbg_grant`.
- Starvation counter `starve_cnt`, width $clog2(STARVE_MAX+1):
  - increments when `dbg_valid & !dbg_grant`;
  - clears on a debug grant or when `!dbg_valid`;
  - `starve_hit = (starve_cnt == STARVE_MAX)`.
- Read owner register, type `rd_owner_t` {OWN_NONE, OWN_CPU, OWN_DBG}, records who issued `mem_ren` in the previous cycle.
- `cpu_rdata`:
  - equals `mem_rdata` when the owner is OWN_CPU;
  - otherwise equals `cpu_rdata_q`, which captures `mem_rdata` on every OWN_CPU cycle.
- `dbg_rdata = mem_rdata`. `dbg_rvalid = (owner == OWN_DBG)`.

## Timing
- Grant, `cpu_stall`, `dbg_ready`, and all `mem_*` request outputs are combinational in the same cycle as the request.
- Read latency is 1 cycle for both requesters. `dbg_rvalid` pulses for exactly 1 cycle, 1 cycle after the accepted debug read.
- Debug write takes effect at the granted clock edge. Debug read-after-write to the same address is ordered by acceptance.
- Worst-case debug wait with the CPU saturating is STARVE_MAX cycles. The grant lands in cycle STARVE_MAX+1.
- Debug may be granted back-to-back only when the CPU is idle or `dbg_halt` is set.
- Reset values:
  - `starve_cnt` = 0, owner = OWN_NONE, `cpu_rdata_q` = 0;
  - `dbg_rvalid` = 0, `cpu_rdata` = 0;
  - during `rst`: `mem_ren` = `mem_wen` = 0, `dbg_ready` = 0, `cpu_stall` = 0.
- Reset the cycle after a debug read grant: the response is dropped and `dbg_rvalid` stays 0.
- `dbg_halt` takes effect in the same cycle it is asserted. Releasing it returns priority to the CPU in the same cycle.

## Configuration
- `SVC_RV_DMEM_ARB_STARVE_EN` defined: starvation guard present, as above.
- Not defined:
  - `starve_hit` = 0 and the counter is not built;
  - strict CPU priority: debug is granted only when `!cpu_req` or `dbg_halt`;
  - `STARVE_MAX` is ignored.

## Structure
- `rd_owner_t` goes in `svc_rv_pkg`.
- One sub-module, `svc_rv_dmem_arb_starve`: the counter and comparator, instantiated under the macro.
- Grant logic, owner register, and rdata hold live in the top module.

## Test plan
- CPU read 0x10 preloaded 0xDEADBEEF, no debug -> `cpu_rdata` = 0xDEADBEEF next cycle; `cpu_stall` = 0 throughout.
- CPU idle; debug write 0x20 = 0x00001234 strb 0xF, then debug read 0x20 -> `dbg_ready` high both cycles; `dbg_rvalid` one cycle after the read with `dbg_rdata` = 0x00001234.
- STARVE_MAX = 4; CPU reads every cycle; `dbg_valid` held -> debug granted in cycle 5 only; `cpu_stall` high in that cycle only; counter returns to 0. With the macro undefined, debug is never granted.
- CPU read 0x10 returns 0xAAAA0000, then debug read 0x30 (0x5555) steals the next cycle -> `cpu_rdata` stays 0xAAAA0000; `dbg_rdata` = 0x5555.
- `dbg_halt` = 1 with CPU requesting continuously -> `cpu_stall` = 1 every cycle; debug accepted every cycle; no `mem_wen` from CPU writes.
- `rst` asserted the cycle after a debug read grant -> `dbg_rvalid` stays 0; `starve_cnt` = 0; `mem_ren` = 0 during reset.
